// File: rtl/link_tx_sched.sv
// Link-layer transmit scheduler: arbitrates handshake/token/data sources, issues one packet at a time.
// Optional per-type grant and timeout counters are enabled with `define LINK_TX_SCHED_STATS_EN.
module link_tx_sched #(
    parameter int IPG     = 4,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       hs_req,
    input  logic [3:0] hs_pid,
    output logic       hs_gnt,
    input  logic       tok_req,
    input  logic [3:0] tok_pid,
    input  logic [6:0] tok_addr,
    output logic       tok_gnt,
    input  logic       dat_req,
    input  logic [3:0] dat_pid,
    input  logic [7:0] dat_byte,
    output logic       dat_gnt,
    output logic       start,
    output logic [1:0] pkt_type,
    output logic [3:0] tx_pid,
    output logic [6:0] tx_addr,
    output logic [7:0] tx_lt_data,
    input  logic       done,
    output logic       busy,
    output logic       err_timeout
`ifdef LINK_TX_SCHED_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [15:0] cnt_tok,
    output logic [15:0] cnt_dat,
    output logic [15:0] cnt_hs,
    output logic [7:0]  cnt_to
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] IPG_LAST = CW'(IPG - 1);

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          rr_dat_reg;   // 1: data source has the next tie-break
    logic          win_hs, win_tok, win_dat, win_any;
    logic          timeout_hit;

    always_comb begin
        win_hs  = 1'b0;
        win_tok = 1'b0;
        win_dat = 1'b0;
        if (state_reg == IDLE && tx_en) begin
            if (hs_req)
                win_hs = 1'b1;
            else if (tok_req && dat_req) begin
                win_dat = rr_dat_reg;
                win_tok = !rr_dat_reg;
            end else begin
                win_tok = tok_req;
                win_dat = dat_req;
            end
        end
    end

    assign win_any     = win_hs | win_tok | win_dat;
    // done in the last allowed cycle takes precedence over the abort
    assign timeout_hit = (state_reg == WAIT_DONE) && !done && (cnt_reg == TO_LAST);
    assign busy        = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rr_dat_reg  <= 1'b0;
            hs_gnt      <= 1'b0;
            tok_gnt     <= 1'b0;
            dat_gnt     <= 1'b0;
            start       <= 1'b0;
            pkt_type    <= 2'b00;
            tx_pid      <= 4'h0;
            tx_addr     <= 7'h00;
            tx_lt_data  <= 8'h00;
            err_timeout <= 1'b0;
        end else begin
            hs_gnt      <= win_hs;
            tok_gnt     <= win_tok;
            dat_gnt     <= win_dat;
            start       <= win_any;
            err_timeout <= timeout_hit;
            case (state_reg)
                IDLE: begin
                    if (win_any) begin
                        state_reg <= WAIT_DONE;
                        cnt_reg   <= '0;
                    end
                    if (win_hs) begin
                        pkt_type   <= 2'b10;
                        tx_pid     <= hs_pid;
                        tx_addr    <= 7'h00;
                        tx_lt_data <= 8'h00;
                    end else if (win_tok) begin
                        pkt_type   <= 2'b00;
                        tx_pid     <= tok_pid;
                        tx_addr    <= tok_addr;
                        tx_lt_data <= 8'h00;
                        rr_dat_reg <= 1'b1;
                    end else if (win_dat) begin
                        pkt_type   <= 2'b01;
                        tx_pid     <= dat_pid;
                        tx_addr    <= 7'h00;
                        tx_lt_data <= dat_byte;
                        rr_dat_reg <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (done || timeout_hit) begin
                        cnt_reg   <= '0;
                        state_reg <= (IPG == 0) ? IDLE : GAP;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_reg == IPG_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef LINK_TX_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_tok <= '0;
            cnt_dat <= '0;
            cnt_hs  <= '0;
            cnt_to  <= '0;
        end else if (stats_clr) begin
            cnt_tok <= '0;
            cnt_dat <= '0;
            cnt_hs  <= '0;
            cnt_to  <= '0;
        end else begin
            if (win_tok && cnt_tok != 16'hFFFF) cnt_tok <= cnt_tok + 16'd1;
            if (win_dat && cnt_dat != 16'hFFFF) cnt_dat <= cnt_dat + 16'd1;
            if (win_hs  && cnt_hs  != 16'hFFFF) cnt_hs  <= cnt_hs  + 16'd1;
            if (timeout_hit && cnt_to != 8'hFF) cnt_to  <= cnt_to  + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_link_tx_sched.sv
// Directed bench for link_tx_sched: expected packets are queued as requests are raised
// and popped when start appears; timing relations are checked against the cycle counter.
module tb_link_tx_sched;

    localparam int IPG     = 4;
    localparam int TIMEOUT = 1024;
    localparam int CW      = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       hs_req = 1'b0, tok_req = 1'b0, dat_req = 1'b0;
    logic [3:0] hs_pid = 4'h2, tok_pid = 4'h1, dat_pid = 4'h3;
    logic [6:0] tok_addr = 7'h05;
    logic [7:0] dat_byte = 8'hC3;
    logic       done = 1'b0;
    logic       hs_gnt, tok_gnt, dat_gnt, start, busy, err_timeout;
    logic [1:0] pkt_type;
    logic [3:0] tx_pid;
    logic [6:0] tx_addr;
    logic [7:0] tx_lt_data;
`ifdef LINK_TX_SCHED_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] cnt_tok, cnt_dat, cnt_hs;
    logic [7:0]  cnt_to;
`endif

    link_tx_sched #(.IPG(IPG), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
        .hs_req(hs_req), .hs_pid(hs_pid), .hs_gnt(hs_gnt),
        .tok_req(tok_req), .tok_pid(tok_pid), .tok_addr(tok_addr), .tok_gnt(tok_gnt),
        .dat_req(dat_req), .dat_pid(dat_pid), .dat_byte(dat_byte), .dat_gnt(dat_gnt),
        .start(start), .pkt_type(pkt_type), .tx_pid(tx_pid), .tx_addr(tx_addr),
        .tx_lt_data(tx_lt_data), .done(done), .busy(busy), .err_timeout(err_timeout)
`ifdef LINK_TX_SCHED_STATS_EN
        , .stats_clr(stats_clr), .cnt_tok(cnt_tok), .cnt_dat(cnt_dat),
        .cnt_hs(cnt_hs), .cnt_to(cnt_to)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0] typ;
        logic [3:0] pid;
        logic [6:0] addr;
        logic [7:0] data;
        logic [2:0] gnt;   // {hs, tok, dat}
    } exp_t;

    exp_t       sb[$];
    int         last_start;
    logic [2:0] last_g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_hs();
        exp_t e;
        e.typ = 2'b10; e.pid = hs_pid; e.addr = 7'h00; e.data = 8'h00; e.gnt = 3'b100;
        sb.push_back(e);
    endtask

    task automatic push_tok();
        exp_t e;
        e.typ = 2'b00; e.pid = tok_pid; e.addr = tok_addr; e.data = 8'h00; e.gnt = 3'b010;
        sb.push_back(e);
    endtask

    task automatic push_dat();
        exp_t e;
        e.typ = 2'b01; e.pid = dat_pid; e.addr = 7'h00; e.data = dat_byte; e.gnt = 3'b001;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hs_req = 1'b0; tok_req = 1'b0; dat_req = 1'b0; done = 1'b0; tx_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
    endtask

    // Wait for start, check it against the scoreboard head, and drop the granted request.
    task automatic wait_start(input int bound);
        int   n;
        exp_t e;
        n = 0;
        while (start !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (start !== 1'b1) begin
            chk("start_seen", 64'(start), 64'(1));
            last_start = -1;
            last_g = 3'b000;
            return;
        end
        last_start = cyc;
        last_g = {hs_gnt, tok_gnt, dat_gnt};
        if (sb.size() == 0) begin
            chk("unexpected_start", 64'(sb.size()), 64'(1));
        end else begin
            e = sb.pop_front();
            chk("fields", 64'({pkt_type, tx_pid, tx_addr, tx_lt_data}),
                64'({e.typ, e.pid, e.addr, e.data}));
            chk("grant", 64'(last_g), 64'(e.gnt));
        end
        if (last_g[2]) hs_req = 1'b0;
        if (last_g[1]) tok_req = 1'b0;
        if (last_g[0]) dat_req = 1'b0;
    endtask

    // Deliver done d cycles after start, then check the gap and return to IDLE.
    task automatic finish_pkt(input int d, input bit rekeep);
        for (int k = 0; k < d; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("start_pulse", 64'({start, hs_gnt, tok_gnt, dat_gnt}), 64'(0));
                if (rekeep) begin
                    tok_req = tok_req | last_g[1];
                    dat_req = dat_req | last_g[0];
                end
            end
        end
        done = 1'b1;
        for (int k = 0; k < IPG; k++) begin
            @(negedge clk);
            done = 1'b0;
            chk("gap_busy", 64'(busy), 64'(1));
        end
        @(negedge clk);
        done = 1'b0;
        chk("idle_after_gap", 64'(busy), 64'(0));
    endtask

    task automatic run_pkt(input int d, input bit rekeep);
        wait_start(200);
        if (last_start >= 0) finish_pkt(d, rekeep);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, p, c0, n, errs, starts;

        // reset state
        @(negedge clk);
        chk("reset_outputs", 64'({start, busy, hs_gnt, tok_gnt, dat_gnt, pkt_type, tx_pid,
                                  tx_addr, tx_lt_data, err_timeout}), 64'(0));
        do_reset();

        // single token, start one cycle after request
        tok_req = 1'b1; push_tok(); c0 = cyc;
        run_pkt(20, 1'b0);
        chk("tok_latency", 64'(last_start - c0), 64'(1));

        // simultaneous requests: hs, tok, dat with fixed spacing
        do_reset();
        hs_req = 1'b1; tok_req = 1'b1; dat_req = 1'b1;
        push_hs(); push_tok(); push_dat();
        run_pkt(10, 1'b0); p = last_start;
        run_pkt(10, 1'b0);
        chk("spacing_1", 64'(last_start - p), 64'(10 + IPG + 2)); p = last_start;
        run_pkt(10, 1'b0);
        chk("spacing_2", 64'(last_start - p), 64'(10 + IPG + 2));

        // fairness with a handshake injected mid-sequence
        do_reset();
        tok_req = 1'b1; dat_req = 1'b1;
        push_tok(); push_dat(); push_tok();
        run_pkt(4, 1'b1);
        run_pkt(4, 1'b1);
        wait_start(200);
        hs_req = 1'b1;
        push_hs(); push_dat(); push_tok(); push_dat();
        finish_pkt(4, 1'b1);
        run_pkt(4, 1'b1);
        run_pkt(4, 1'b1);
        run_pkt(4, 1'b1);
        run_pkt(4, 1'b1);

        // timeout on a data packet, then the pending token is served
        do_reset();
        dat_req = 1'b1; push_dat();
        wait_start(10); s = last_start;
        tok_req = 1'b1; push_tok();
        n = 0;
        while (err_timeout !== 1'b1 && n < TIMEOUT + 20) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycle", 64'(cyc - s), 64'(TIMEOUT));
        @(negedge clk);
        chk("timeout_pulse", 64'(err_timeout), 64'(0));
        run_pkt(6, 1'b0);
        chk("after_timeout_start", 64'(last_start - s), 64'(TIMEOUT + IPG + 1));

        // done in the same cycle as the timeout: no error
        do_reset();
        tok_req = 1'b1; push_tok();
        wait_start(10);
        repeat (TIMEOUT - 1) @(negedge clk);
        done = 1'b1; errs = 0;
        for (int i = 1; i <= IPG + 3; i++) begin
            @(negedge clk);
            done = 1'b0;
            if (err_timeout === 1'b1) errs++;
            if (i == IPG + 1) chk("coincide_idle", 64'(busy), 64'(0));
        end
        chk("coincide_no_err", 64'(errs), 64'(0));

        // tx_en low blocks grants; deasserting mid-packet lets it finish
        do_reset();
        tx_en = 1'b0; tok_req = 1'b1; starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (start === 1'b1) starts++;
        end
        chk("tx_en_off_no_start", 64'(starts), 64'(0));
        tx_en = 1'b1; push_tok();
        wait_start(5);
        tx_en = 1'b0; dat_req = 1'b1;
        finish_pkt(5, 1'b0);
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (start === 1'b1) starts++;
        end
        chk("tx_en_mid_no_start", 64'(starts), 64'(0));
        tx_en = 1'b1; push_dat();
        run_pkt(3, 1'b0);

        // reset in WAIT_DONE clears outputs at once, no restart after release
        do_reset();
        tok_req = 1'b1; push_tok();
        wait_start(5);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({start, busy, hs_gnt, tok_gnt, dat_gnt, pkt_type, tx_pid,
                                        tx_addr, tx_lt_data, err_timeout}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1; starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (start === 1'b1) starts++;
        end
        chk("no_stray_start", 64'(starts), 64'(0));

`ifdef LINK_TX_SCHED_STATS_EN
        do_reset();
        hs_req = 1'b1; push_hs(); run_pkt(3, 1'b0);
        tok_req = 1'b1; push_tok(); run_pkt(3, 1'b0);
        dat_req = 1'b1; push_dat();
        wait_start(10);
        n = 0;
        while (err_timeout !== 1'b1 && n < TIMEOUT + 20) begin
            @(negedge clk);
            n++;
        end
        tok_req = 1'b1; push_tok(); run_pkt(3, 1'b0);
        dat_req = 1'b1; push_dat(); run_pkt(3, 1'b0);
        tok_req = 1'b1; push_tok(); run_pkt(3, 1'b0);
        chk("stats_counts", 64'({cnt_tok, cnt_dat, cnt_hs, cnt_to}),
            64'({16'd3, 16'd2, 16'd1, 8'd1}));
        tok_req = 1'b1; stats_clr = 1'b1; push_tok();
        @(negedge clk);
        stats_clr = 1'b0;
        wait_start(5);
        chk("stats_clr_wins", 64'({cnt_tok, cnt_dat, cnt_hs, cnt_to}), 64'(0));
        finish_pkt(3, 1'b0);
`endif

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
